// File: rtl/dma_copy_engine.sv
// Word-copy DMA engine sharing a single-port SRAM with the CTL; CTL always wins.
// Optional abort input enabled by defining DMA_ABORT_EN.
module dma_copy_engine #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              cpu_mem_busy,
`ifdef DMA_ABORT_EN
  input  logic              abort,
`endif
  output logic              dma_REQ,
  output logic [ADDR_W-1:0] dma_ADDR,
  output logic [DATA_W-1:0] dma_DI,
  output logic              dma_WE,
  input  logic [DATA_W-1:0] sram_DO,
  output logic              busy,
  output logic [ADDR_W-1:0] remaining,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    WRITE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] di_q, di_d;
  logic              done_q, done_d;
  logic              g;
  logic              ab;

  assign g = !cpu_mem_busy;

`ifdef DMA_ABORT_EN
  assign ab = abort;
`else
  assign ab = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      di_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      di_q    <= di_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    di_d    = di_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          src_d = cmd_src;
          dst_d = cmd_dst;
          rem_d = cmd_len;
          if (cmd_len == '0) done_d = 1'b1;
          else state_d = READ;
        end
      end
      READ: begin
        if (ab) begin
          state_d = IDLE;
        end else if (g) begin
          src_d   = src_q + 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ab) begin
          state_d = IDLE;
        end else begin
          di_d    = sram_DO;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // An abort here lets the granted write land before stopping
        if (g) begin
          dst_d = dst_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == {{(ADDR_W-1){1'b0}}, 1'b1}) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (ab) begin
            state_d = IDLE;
          end else begin
            state_d = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dma_ADDR = '0;
    if (state_q == READ)  dma_ADDR = src_q;
    if (state_q == WRITE) dma_ADDR = dst_q;
  end

  assign dma_REQ   = g && (state_q == READ || state_q == WRITE);
  assign dma_WE    = g && (state_q == WRITE);
  assign dma_DI    = di_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign remaining = rem_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Bench for dma_copy_engine: SRAM model, reference copy array, random traffic.
// Abort scenario is compiled in when DMA_ABORT_EN is defined.
module tb_dma_copy_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_src;
  logic [15:0] cmd_dst;
  logic [15:0] cmd_len;
  logic        cpu_mem_busy;
  logic        dma_REQ;
  logic [15:0] dma_ADDR;
  logic [31:0] dma_DI;
  logic        dma_WE;
  logic [31:0] sram_DO;
  logic        busy;
  logic [15:0] remaining;
  logic        done;
`ifdef DMA_ABORT_EN
  logic        abort;
`endif

  logic [31:0] mem     [65536];
  logic [31:0] exp_mem [65536];
  logic [15:0] cpu_addr;
  int          cyc    = 0;
  int          wcount = 0;
  int          viol   = 0;
  int          nerr   = 0;
  int          nchk   = 0;

  always #5 clk = ~clk;

  dma_copy_engine dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_src      (cmd_src),
    .cmd_dst      (cmd_dst),
    .cmd_len      (cmd_len),
    .cpu_mem_busy (cpu_mem_busy),
`ifdef DMA_ABORT_EN
    .abort        (abort),
`endif
    .dma_REQ      (dma_REQ),
    .dma_ADDR     (dma_ADDR),
    .dma_DI       (dma_DI),
    .dma_WE       (dma_WE),
    .sram_DO      (sram_DO),
    .busy         (busy),
    .remaining    (remaining),
    .done         (done)
  );

  // SRAM: mux on dma_REQ, one-cycle read latency
  always @(posedge clk) begin
    cyc++;
    if (dma_REQ) begin
      if (dma_WE) mem[dma_ADDR] = dma_DI;
      sram_DO <= mem[dma_ADDR];
    end else begin
      sram_DO <= mem[cpu_addr];
    end
    if (!reset) begin
      if (dma_WE) wcount++;
      if (dma_REQ && cpu_mem_busy) viol++;
      if (dma_WE && !dma_REQ) viol++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < 65536; i++)
      if (mem[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  // Reference: ascending word-by-word copy with 16-bit wrap
  task automatic ref_copy(input logic [15:0] s, input logic [15:0] d,
                          input int n);
    for (int i = 0; i < n; i++)
      exp_mem[16'(d + i)] = exp_mem[16'(s + i)];
  endtask

  // mode 0: no contention, 1: random, 2: CTL busy in T+1..T+3
  task automatic run_copy(input string tag, input logic [15:0] s,
                          input logic [15:0] d, input logic [15:0] l,
                          input int mode, input int want_lat);
    int wc0, v0, k;
    bit got;
    ref_copy(s, d, int'(l));
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_src = s;
    cmd_dst = d;
    cmd_len = l;
    cpu_mem_busy = 1'b0;
    wc0 = wcount;
    v0 = viol;
    got = 1'b0;
    k = 0;
    while (!got && k < 400) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      k++;
      if (done) begin
        got = 1'b1;
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      end
      cpu_addr = 16'($urandom);
      case (mode)
        1: cpu_mem_busy = ($urandom_range(0, 2) == 0);
        2: cpu_mem_busy = (k >= 1 && k <= 3);
        default: cpu_mem_busy = 1'b0;
      endcase
    end
    cpu_mem_busy = 1'b0;
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    if (want_lat >= 0) chk({tag, "_latency"}, 64'(k), 64'(want_lat));
    chk({tag, "_remaining"}, 64'(remaining), 64'd0);
    chk({tag, "_writes"}, 64'(wcount - wc0), 64'(l));
    chk({tag, "_grant_viol"}, 64'(viol - v0), 64'd0);
    chk({tag, "_mem"}, 64'(mem_diffs()), 64'd0);
  endtask

  initial begin
    int wc0, k;
    logic [15:0] s, d, l;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_src = '0;
    cmd_dst = '0;
    cmd_len = '0;
    cpu_mem_busy = 1'b0;
    cpu_addr = '0;
`ifdef DMA_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < 65536; i++) begin
      mem[i] = $urandom;
      exp_mem[i] = mem[i];
    end
    mem[16'h0010] = 32'hDEADBEEF;
    exp_mem[16'h0010] = 32'hDEADBEEF;

    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_req", 64'(dma_REQ), 64'd0);
    chk("rst_we", 64'(dma_WE), 64'd0);
    chk("rst_addr", 64'(dma_ADDR), 64'd0);
    chk("rst_di", 64'(dma_DI), 64'd0);
    chk("rst_rem", 64'(remaining), 64'd0);
    reset = 1'b0;

    // Single word, cycle by cycle
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_src = 16'h0010;
    cmd_dst = 16'h0020;
    cmd_len = 16'd1;
    ref_copy(16'h0010, 16'h0020, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("w1_t1_req", 64'(dma_REQ), 64'd1);
    chk("w1_t1_addr", 64'(dma_ADDR), 64'h10);
    chk("w1_t1_we", 64'(dma_WE), 64'd0);
    @(negedge clk);
    chk("w1_t2_req", 64'(dma_REQ), 64'd0);
    @(negedge clk);
    chk("w1_t3_we", 64'(dma_WE), 64'd1);
    chk("w1_t3_addr", 64'(dma_ADDR), 64'h20);
    chk("w1_t3_di", 64'(dma_DI), 64'hDEADBEEF);
    @(negedge clk);
    chk("w1_t4_done", 64'(done), 64'd1);
    chk("w1_t4_busy", 64'(busy), 64'd0);
    chk("w1_mem", 64'(mem[16'h0020]), 64'hDEADBEEF);
    @(negedge clk);
    chk("w1_done_1cyc", 64'(done), 64'd0);

    run_copy("len4", 16'h0100, 16'h0200, 16'd4, 0, 13);
    run_copy("contend", 16'h0050, 16'h0060, 16'd1, 2, 7);

    // Zero length, then immediate follow-up command
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_src = 16'h0070;
    cmd_dst = 16'h0080;
    cmd_len = 16'd0;
    @(negedge clk);
    chk("len0_done", 64'(done), 64'd1);
    chk("len0_req", 64'(dma_REQ), 64'd0);
    chk("len0_ready", 64'(cmd_ready), 64'd1);
    cmd_len = 16'd1;
    ref_copy(16'h0070, 16'h0080, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("len0_next_busy", 64'(busy), 64'd1);
    k = 0;
    while (!done && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("len0_next_done", 64'(done), 64'd1);
    chk("len0_next_mem", 64'(mem_diffs()), 64'd0);

    run_copy("wrap", 16'hFFFF, 16'h0010, 16'd2, 0, 7);

    // Reset after the second write of a four-word copy
    ref_copy(16'h0300, 16'h0400, 2);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_src = 16'h0300;
    cmd_dst = 16'h0400;
    cmd_len = 16'd4;
    wc0 = wcount;
    k = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (wcount - wc0 < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rstmid_two_writes", 64'(wcount - wc0), 64'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_rem", 64'(remaining), 64'd0);
    wc0 = wcount;
    repeat (20) @(negedge clk);
    chk("rstmid_no_we", 64'(wcount - wc0), 64'd0);
    chk("rstmid_mem", 64'(mem_diffs()), 64'd0);

`ifdef DMA_ABORT_EN
    ref_copy(16'h0500, 16'h0600, 1);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_src = 16'h0500;
    cmd_dst = 16'h0600;
    cmd_len = 16'd3;
    wc0 = wcount;
    k = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (wcount - wc0 < 1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ready", 64'(cmd_ready), 64'd1);
    chk("abort_rem", 64'(remaining), 64'd2);
    chk("abort_done", 64'(done), 64'd0);
    k = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) k++;
    end
    chk("abort_no_done", 64'(k), 64'd0);
    chk("abort_writes", 64'(wcount - wc0), 64'd1);
    chk("abort_mem", 64'(mem_diffs()), 64'd0);
`endif

    // Random commands, including overlaps, under random contention
    for (int t = 0; t < 8; t++) begin
      s = 16'($urandom);
      d = (t % 2 == 0) ? 16'(s + $urandom_range(1, 4)) : 16'($urandom);
      l = 16'($urandom_range(1, 8));
      run_copy($sformatf("rnd%0d", t), s, d, l, 1, -1);
    end
    run_copy("rnd_free", 16'($urandom), 16'($urandom), 16'd5, 0, 16);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
